// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 encodings, FSM state
// constants and the access-legality rule used when a request is captured.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_RESP = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    // Unsupported encodings and accesses not aligned to their own size are rejected
    function automatic logic is_illegal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
            bad = 1'b1;
        if (!is_load && f3[2])
            bad = 1'b1;
        if (f3[1:0] == 2'b01 && lo[0])
            bad = 1'b1;
        if (f3[1:0] == 2'b10 && lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and data replication, and load
// extraction with sign or zero extension.
module lsu_align #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [DATA_W-1:0]   wd_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be_o    = '1;
        wdata_o = wd_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = BE_W'(1) << addr_lo_i;
                wdata_o = {(DATA_W/8){wd_i[7:0]}};
            end
            2'b01: begin
                be_o    = BE_W'(3) << {addr_lo_i[1], 1'b0};
                wdata_o = {(DATA_W/16){wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend by funct3[2]
    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = rdata_i;
        case (funct3_i[1:0])
            2'b00: rdata_o = {{(DATA_W-8){shifted[7] & ~funct3_i[2]}}, shifted[7:0]};
            2'b01: rdata_o = {{(DATA_W-16){shifted[15] & ~funct3_i[2]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures one access from the pipeline, runs it over the
// request/grant/rvalid memory bus and reports completion or rejection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    lsu_if.master             mem
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [2:0]        f3_q, f3_d;
    logic              load_q, load_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   loadVal;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wd_i      (wd_q),
        .rdata_i   (mem.mem_rdata),
        .be_o      (be),
        .wdata_o   (wdata),
        .rdata_o   (loadVal)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        f3_d    = f3_q;
        load_d  = load_q;
        bad_d   = bad_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = addr;
                    wd_d    = wd;
                    f3_d    = Funct3;
                    load_d  = MemRead;
                    bad_d   = is_illegal(MemRead, Funct3, addr[1:0]);
                    state_d = bad_d ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt)
                    state_d = load_q ? ST_RESP : ST_DONE;
            end
            ST_RESP: begin
                if (mem.mem_rvalid) begin
                    rd_d    = loadVal;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            bad_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            bad_q   <= bad_d;
            rd_q    <= rd_d;
        end
    end

    // Strobes are only live while requesting so the bus is quiet otherwise
    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = (state_q == ST_REQ) && !load_q;
    assign mem.mem_be    = (state_q == ST_REQ) ? be : '0;
    assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = wdata;

    assign rd         = rd_q;
    assign done       = (state_q == ST_DONE);
    assign misaligned = (state_q == ST_DONE) && bad_q;
    assign stall      = ((state_q == ST_IDLE) && (MemRead || MemWrite)) ||
                        (state_q == ST_REQ) || (state_q == ST_RESP);

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data width of the pipeline and memory data paths.
REQ-002 Parameter ADDR_W, default 32, SHALL set the width of the byte address from the ALU.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 MemRead  in  1  SHALL be the load request from the control unit.
REQ-006 MemWrite  in  1  SHALL be the store request from the control unit.
REQ-007 Funct3  in  3  SHALL be instruction bits 14:12 selecting access size and signedness.
REQ-008 addr  in  ADDR_W  SHALL be the byte address (ALU result).
REQ-009 wd  in  DATA_W  SHALL be the store data from rs2.
REQ-010 rd  out  DATA_W  SHALL be the aligned, extended load result.
REQ-011 stall  out  1  SHALL hold the pipeline while an access is in flight.
REQ-012 done  out  1  SHALL pulse for one cycle when an access completes.
REQ-013 misaligned  out  1  SHALL pulse with done when the access was rejected.
REQ-014 mem_req, mem_we  out  1 each  SHALL be the request and write strobe to data memory.
REQ-015 mem_addr  out  ADDR_W  SHALL be the word-aligned address (addr[1:0] forced to 00).
REQ-016 mem_be  out  4  SHALL be the byte enables; mem_wdata  out  DATA_W  SHALL be the lane-positioned store data.
REQ-017 mem_gnt, mem_rvalid  in  1 each; mem_rdata  in  DATA_W  SHALL be the memory grant, read-valid and read word.

Function
REQ-018 FSM states SHALL be IDLE, REQ, RESP and DONE.
REQ-019 IDLE: MemRead or MemWrite high SHALL register addr, wd, Funct3 and the operation type, then go to REQ, or go to DONE when the access is illegal.
REQ-020 When MemRead and MemWrite are both high, the load SHALL win.
REQ-021 Illegal accesses SHALL be: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; Funct3 in {011,110,111}; store Funct3 >= 011.
REQ-022 An illegal access SHALL issue no memory request and SHALL go IDLE->DONE with misaligned=1; rd SHALL be held.
REQ-023 REQ: mem_req SHALL be 1 with mem_addr/mem_be/mem_wdata/mem_we stable until mem_gnt=1; a store then goes to DONE, a load to RESP.
REQ-024 RESP: on mem_rvalid=1, rd SHALL be loaded with the extracted mem_rdata and the FSM goes to DONE.
REQ-025 mem_rvalid outside RESP, and mem_gnt outside REQ, SHALL be ignored.
REQ-026 DONE: done=1 and stall=0 for exactly one cycle, then IDLE; request inputs SHALL be ignored in DONE.
REQ-027 stall SHALL equal (IDLE and (MemRead or MemWrite)) or state in {REQ, RESP}.
REQ-028 Store lanes: SB be=0001<<addr[1:0], with wd[7:0] replicated to all bytes; SH be=0011<<(2*addr[1]), with wd[15:0] replicated; SW be=1111.
REQ-029 Load extract: byte/half SHALL be selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-030 Minimum latency SHALL be: store 3 cycles with gnt in the first REQ cycle; load 4 cycles with rvalid in the first RESP cycle.

Reset
REQ-031 On reset: state=IDLE; rd=0; mem_req, mem_we, mem_be, done, misaligned=0; mem_addr and mem_wdata=0.
REQ-032 Reset asserted in REQ or RESP SHALL abort the access and drop mem_req the next cycle, with no done pulse.

Structure
REQ-033 Package lsu_pkg SHALL hold the Funct3 encodings (LB..LHU, SB..SW) and the FSM state enum.
REQ-034 Combinational sub-module lsu_align SHALL hold the byte-enable/store-replication and load-extract logic.

Verification
REQ-035 SB addr=0x0000_0106, wd=0x1234_56AB, gnt immediate -> mem_addr=0x104, mem_be=0100, mem_wdata=0xABABABAB, done at cycle 3.
REQ-036 LB addr=0x103, rdata=0x80FF_0000 -> rd=0xFFFF_FF80; same access as LBU -> rd=0x0000_0080.
REQ-037 LW addr=0x102 -> no mem_req, done=1 and misaligned=1 in the following cycle, rd unchanged.
REQ-038 LH addr=0x0, gnt delayed 3 cycles and rvalid delayed 2 cycles -> mem_req held 4 cycles, stall high throughout, rdata=0x0000_8001 -> rd=0xFFFF_8001.
REQ-039 MemRead and MemWrite both high -> load is performed and mem_we=0.
REQ-040 Reset asserted in RESP, then a stray rvalid arrives -> FSM in IDLE, rd=0, no done pulse.
